// File: rtl/output_argmax.sv
// output_argmax: scans one GSRAM column and returns the signed-argmax row index over valid/ready (optional max_score output via ARGMAX_SCORE_OUT_EN)
module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] col_sel,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_row,
  output logic [ADDR_W-1:0] rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [DATA_W-1:0] max_score,
`endif
  output logic [ADDR_W-1:0] class_idx
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_cnt, r_col, r_rrow, r_idx;
  logic [DATA_W-1:0]   r_max;
  logic                r_rv, r_first;
  logic                w_last, w_take;
  assign w_last = r_cnt == ADDR_W'(NUM_CLASSES - 1);
  assign w_take = r_rv && (r_first || $signed(rd_data) > $signed(r_max));
  assign rd_row = r_cnt;
  assign rd_col = r_col;
  assign class_idx = r_idx;
`ifdef ARGMAX_SCORE_OUT_EN
  assign max_score = r_max;
`endif
  // state register; reset drops all state-decoded outputs immediately
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  // next-state and state-decoded outputs
  always_comb begin
    w_next    = r_state;
    busy      = r_state != IDLE;
    rd_en     = r_state == SCAN;
    out_valid = r_state == DONE;
    unique case (r_state)
      IDLE:    if (start) w_next = SCAN;
      SCAN:    if (w_last) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // read counter, column latch and one-cycle-delayed compare pipeline;
  // strict greater-than over ascending rows keeps the lowest index on ties
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt   <= '0;
      r_col   <= '0;
      r_rv    <= 1'b0;
      r_rrow  <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
    end else begin
      r_rv   <= rd_en;
      r_rrow <= r_cnt;
      if (w_take) begin
        r_max   <= rd_data;
        r_idx   <= r_rrow;
        r_first <= 1'b0;
      end
      if (r_state == IDLE && start) begin
        r_col   <= col_sel;
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (r_state == SCAN && !w_last) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax: directed self-checking bench for output_argmax with a 1-cycle-latency GSRAM model
module tb_output_argmax;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic [3:0]  col_sel = 0;
  logic        busy, rd_en, out_valid;
  logic [3:0]  rd_row, rd_col, class_idx;
  logic [15:0] rd_data = 0;
  logic        out_ready = 0;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [15:0] max_score;
`endif
  logic [15:0] mem [0:15][0:15];
  int checks = 0;
  int errors = 0;

  output_argmax dut (
    .clk(clk), .reset_n(reset_n), .start(start), .col_sel(col_sel),
    .busy(busy), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ARGMAX_SCORE_OUT_EN
    .max_score(max_score),
`endif
    .class_idx(class_idx)
  );

  always #5 clk = ~clk;

  // GSRAM model: data valid one cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_row][rd_col];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_col(input int col, input logic [159:0] v);
    for (int i = 0; i < 10; i++) mem[i][col] = v[16*(9-i) +: 16];
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic run_scan(input int col, input int eidx, input logic [15:0] escore,
                          input int stall, input bit start_at_hs);
    start = 1; col_sel = 4'(col);
    tick;
    start = 0; col_sel = ~4'(col);
    chk("acc_busy", busy, 1);
    chk("acc_rden", rd_en, 1);
    chk("row0", rd_row, 0);
    chk("rdcol", rd_col, col);
    for (int r = 1; r < 10; r++) begin
      tick;
      chk("row", rd_row, r);
      chk("scan_rden", rd_en, 1);
    end
    chk("rdcol_hold", rd_col, col);
    tick;
    chk("drain_rden", rd_en, 0);
    chk("drain_valid", out_valid, 0);
    tick;
    chk("valid", out_valid, 1);
    chk("idx", class_idx, eidx);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("score", max_score, escore);
`else
    if (escore === 16'hxxxx) $display("unused");
`endif
    for (int s = 0; s < stall; s++) begin
      start = (s == 1); col_sel = 4'd2;
      tick;
      chk("stall_valid", out_valid, 1);
      chk("stall_idx", class_idx, eidx);
      chk("stall_busy", busy, 1);
      chk("stall_rden", rd_en, 0);
    end
    start = start_at_hs; out_ready = 1;
    tick;
    start = 0; out_ready = 0;
    chk("hs_valid", out_valid, 0);
    chk("hs_busy", busy, 0);
    if (start_at_hs) begin
      tick;
      chk("hs_start_ignored", busy, 0);
      chk("hs_start_rden", rd_en, 0);
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mem[r][c] = 16'h0;
    set_col(3, {16'd5, 16'd9, 16'd2, 16'd3, 16'd4, 16'd0, 16'd7, 16'd8, 16'd6, 16'd1});
    set_col(0, {16'hFFFD, 16'hFFFD, 16'hFFF9, 16'hFFFC, 16'hFFFB,
                16'hFFF8, 16'hFFF7, 16'hFFF6, 16'hFFFD, 16'hFFFA});
    set_col(5, {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF});
    set_col(7, {16'hFFEC, 16'hFFF1, 16'hFFE2, 16'hFFF4, 16'hFFFE,
                16'hFFFE, 16'hFFD8, 16'hFFCE, 16'hFFF7, 16'hFF9C});
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_row", rd_row, 0);
    chk("rst_col", rd_col, 0);
    chk("rst_idx", class_idx, 0);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("rst_score", max_score, 0);
`endif
    #20 reset_n = 1;
    tick;
    out_ready = 1;
    tick;
    chk("ready_idle_noeffect", out_valid, 0);
    out_ready = 0;
    run_scan(3, 1, 16'd9, 0, 0);
    run_scan(0, 0, 16'hFFFD, 0, 0);
    run_scan(5, 9, 16'h7FFF, 0, 0);
    run_scan(7, 4, 16'hFFFE, 0, 0);
    run_scan(3, 1, 16'd9, 5, 1);
    start = 1; col_sel = 4'd0;
    tick;
    start = 0;
    repeat (4) tick;
    chk("mid_row4", rd_row, 4);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_rden", rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 14; i++) begin
      tick;
      chk("post_rst_valid", out_valid, 0);
    end
    run_scan(3, 1, 16'd9, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
